// File: rtl/darkriscv_data_bridge_if.sv
// Bus bundle between the darkriscv data port, the bridge and the data memory.
// The bridge uses the slave view; the surrounding environment uses the master view.
interface darkriscv_data_bridge_if;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_dlen;
    logic        core_rd;
    logic        core_wr;
    logic [31:0] core_rdata;
    logic        core_hlt;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_response;
    logic        err_misalign;
    logic        err_timeout;

    modport slave (
        input  core_addr, core_wdata, core_dlen, core_rd, core_wr,
        input  mem_rdata, mem_response,
        output core_rdata, core_hlt,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output err_misalign, err_timeout
    );

    modport master (
        output core_addr, core_wdata, core_dlen, core_rd, core_wr,
        output mem_rdata, mem_response,
        input  core_rdata, core_hlt,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  err_misalign, err_timeout
    );
endinterface

// File: rtl/darkriscv_data_bridge.sv
// Data-side bridge for darkriscv: holds memory requests until mem_response, stalls the core
// through HLT, and performs sub-word stores as read-modify-write on the word-only port.
module darkriscv_data_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input logic                    clk,
    input logic                    reset,
    darkriscv_data_bridge_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic [3:0] byte_enable(input logic [2:0] dlen, input logic [1:0] a);
        logic [3:0] be;
        case (dlen)
            3'd1:    be = 4'b0001 << a;
            3'd2:    be = 4'b0011 << a;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] dlen, input logic [1:0] a);
        logic mis;
        case (dlen)
            3'd1:    mis = 1'b0;
            3'd2:    mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return m;
    endfunction

    state_e           state_q, state_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [31:0]      core_rdata_q, core_rdata_d;
    logic             err_misalign_q, err_misalign_d;
    logic             err_timeout_q, err_timeout_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       req_s;
    logic [3:0] be_s;
    logic       misalign_s;
    logic       timeout_s;

    assign req_s      = bus.core_rd | bus.core_wr;
    assign be_s       = byte_enable(bus.core_dlen, bus.core_addr[1:0]);
    assign misalign_s = is_misaligned(bus.core_dlen, bus.core_addr[1:0]);
    assign timeout_s  = (cnt_q == CNT_LAST);

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d        = state_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        core_rdata_d   = core_rdata_q;
        err_misalign_d = 1'b0;
        err_timeout_d  = 1'b0;
        be_d           = be_q;
        wdata_d        = wdata_q;
        cnt_d          = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    mem_addr_d = {bus.core_addr[31:2], 2'b00};
                    cnt_d      = '0;
                    if (misalign_s) begin
                        state_d        = ST_DONE;
                        err_misalign_d = 1'b1;
                        core_rdata_d   = 32'h0000_0000;
                    end else if (bus.core_wr) begin
                        if (be_s == 4'hF) begin
                            state_d     = ST_WRITE;
                            mem_write_d = 1'b1;
                            mem_wdata_d = bus.core_wdata;
                        end else begin
                            state_d    = ST_RMW_RD;
                            mem_read_d = 1'b1;
                            be_d       = be_s;
                            wdata_d    = bus.core_wdata;
                        end
                    end else begin
                        state_d    = ST_READ;
                        mem_read_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                cnt_d = cnt_q + CNT_ONE;
                if (bus.mem_response) begin
                    core_rdata_d = bus.mem_rdata;
                    mem_read_d   = 1'b0;
                    state_d      = ST_DONE;
                end else if (timeout_s) begin
                    core_rdata_d  = ERR_DATA;
                    mem_read_d    = 1'b0;
                    err_timeout_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    state_d = ST_READ;
                end
            end
            // Read half of a sub-word store; the write is launched on the same edge.
            ST_RMW_RD: begin
                cnt_d = cnt_q + CNT_ONE;
                if (bus.mem_response) begin
                    mem_wdata_d = merge_bytes(bus.mem_rdata, wdata_q, be_q);
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b1;
                    state_d     = ST_WRITE;
                end else if (timeout_s) begin
                    mem_read_d    = 1'b0;
                    err_timeout_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    state_d = ST_RMW_RD;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (bus.mem_response) begin
                    mem_write_d = 1'b0;
                    state_d     = ST_DONE;
                end else if (timeout_s) begin
                    mem_write_d   = 1'b0;
                    err_timeout_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset drops any pending memory request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= 32'h0000_0000;
            mem_wdata_q    <= 32'h0000_0000;
            core_rdata_q   <= 32'h0000_0000;
            err_misalign_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            be_q           <= 4'h0;
            wdata_q        <= 32'h0000_0000;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            core_rdata_q   <= core_rdata_d;
            err_misalign_q <= err_misalign_d;
            err_timeout_q  <= err_timeout_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            cnt_q          <= cnt_d;
        end
    end

    // HLT must react in the request cycle itself, so it is decoded from the live inputs.
    assign bus.core_hlt = ((state_q == ST_IDLE) && req_s) ||
                          ((state_q != ST_IDLE) && (state_q != ST_DONE));

    assign bus.mem_read     = mem_read_q;
    assign bus.mem_write    = mem_write_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.core_rdata   = core_rdata_q;
    assign bus.err_misalign = err_misalign_q;
    assign bus.err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_darkriscv_data_bridge.sv
// Randomized bench for darkriscv_data_bridge: a transaction-level timeline model predicts
// every cycle of each access, and a single compare process checks the DUT on each falling edge.
module tb_darkriscv_data_bridge;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    darkriscv_data_bridge_if bus ();

    darkriscv_data_bridge #(
        .TIMEOUT_CYCLES(TMO),
        .ERR_DATA      (32'hDEADBEEF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic        exp_valid = 1'b0;
    logic        exp_hlt, exp_rd, exp_wr, exp_emis, exp_etmo;
    logic        chk_addr, chk_wdata, chk_rdata;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;

    int  mon_hlt, mon_rd, mon_wr;
    logic [31:0] mem_model [logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model's expectations.
    always @(negedge clk) begin
        if (exp_valid) begin
            check("core_hlt",     32'(bus.core_hlt),     32'(exp_hlt));
            check("mem_read",     32'(bus.mem_read),     32'(exp_rd));
            check("mem_write",    32'(bus.mem_write),    32'(exp_wr));
            check("err_misalign", 32'(bus.err_misalign), 32'(exp_emis));
            check("err_timeout",  32'(bus.err_timeout),  32'(exp_etmo));
            if (chk_addr)  check("mem_addr",   bus.mem_addr,   exp_addr);
            if (chk_wdata) check("mem_wdata",  bus.mem_wdata,  exp_wdata);
            if (chk_rdata) check("core_rdata", bus.core_rdata, exp_rdata);
        end
    end

    // Activity counters used by the directed scenarios.
    always @(negedge clk) begin
        if (bus.core_hlt)  mon_hlt++;
        if (bus.mem_read)  mon_rd++;
        if (bus.mem_write) mon_wr++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic hlt, input logic rd, input logic wr,
                           input logic emis, input logic etmo);
        exp_hlt = hlt; exp_rd = rd; exp_wr = wr; exp_emis = emis; exp_etmo = etmo;
        chk_addr = 1'b0; chk_wdata = 1'b0; chk_rdata = 1'b0;
    endtask

    function automatic logic [31:0] mem_get(input logic [31:0] w);
        if (!mem_model.exists(w)) mem_model[w] = $urandom;
        return mem_model[w];
    endfunction

    task automatic clear_mon();
        mon_hlt = 0; mon_rd = 0; mon_wr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.core_rd      = 1'b0;
            bus.core_wr      = 1'b0;
            bus.mem_response = ($urandom_range(0, 3) == 0);
            bus.mem_rdata    = $urandom;
            set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        bus.mem_response = 1'b0;
    endtask

    // One core access. lr/lw = cycle (1-based) of the read/write response; 0 means never.
    task automatic do_txn(input logic [31:0] addr, input logic [2:0] dlen, input logic rd,
                          input logic wr, input logic [31:0] wdata, input int lr, input int lw);
        int          size, off, waited, k;
        bit          mis, aborted, done_ph;
        int          ph_kind[$];
        int          ph_len[$];
        logic [31:0] word, old_w, new_w;
        size  = (dlen == 3'd1) ? 1 : (dlen == 3'd2) ? 2 : 4;
        off   = int'(addr % 4);
        mis   = (off % size) != 0;
        word  = addr - 32'(off);
        old_w = mem_get(word);
        new_w = old_w;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + size) new_w[8*i +: 8] = wdata[8*i +: 8];
        if (!mis) begin
            if (wr) begin
                if (size != 4) begin ph_kind.push_back(1); ph_len.push_back(lr); end
                ph_kind.push_back(2); ph_len.push_back(lw);
            end else begin
                ph_kind.push_back(1); ph_len.push_back(lr);
            end
        end
        bus.core_addr = addr; bus.core_dlen = dlen; bus.core_wdata = wdata;
        bus.core_rd = rd; bus.core_wr = wr; bus.mem_response = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        waited  = 0;
        aborted = 0;
        foreach (ph_kind[p]) begin
            if (aborted) break;
            k = 0;
            done_ph = 0;
            while (!done_ph && !aborted) begin
                k++;
                waited++;
                set_exp(1'b1, ph_kind[p] == 1, ph_kind[p] == 2, 1'b0, 1'b0);
                chk_addr  = 1'b1; exp_addr  = word;
                chk_wdata = (ph_kind[p] == 2); exp_wdata = new_w;
                bus.mem_response = (ph_len[p] != 0) && (k == ph_len[p]);
                bus.mem_rdata    = (bus.mem_response && ph_kind[p] == 1) ? old_w : $urandom;
                cyc();
                if (bus.mem_response) begin
                    if (ph_kind[p] == 2) mem_model[word] = new_w;
                    done_ph = 1;
                end else if (waited == TMO) begin
                    aborted = 1;
                end
            end
        end
        // Completion cycle: stray response and still-high requests must be ignored.
        bus.mem_response = ($urandom_range(0, 2) == 0);
        bus.mem_rdata    = $urandom;
        bus.core_rd      = 1'($urandom_range(0, 1));
        bus.core_wr      = 1'($urandom_range(0, 1));
        set_exp(1'b0, 1'b0, 1'b0, mis, aborted);
        if (mis) begin
            chk_rdata = 1'b1; exp_rdata = 32'h0000_0000;
        end else if (!wr) begin
            chk_rdata = 1'b1; exp_rdata = aborted ? 32'hDEADBEEF : old_w;
        end
        cyc();
        bus.core_rd = 1'b0; bus.core_wr = 1'b0; bus.mem_response = 1'b0;
    endtask

    task automatic random_txn();
        logic [2:0]  dl_tab [6] = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd3, 3'd7};
        logic [31:0] a;
        logic [2:0]  dl;
        logic        rd, wr;
        int          lr, lw;
        a  = 32'($urandom_range(0, 1023));
        dl = dl_tab[$urandom_range(0, 5)];
        if ($urandom_range(0, 2) != 0) begin
            if (dl == 3'd2)      a = a & 32'hFFFF_FFFE;
            else if (dl != 3'd1) a = a & 32'hFFFF_FFFC;
        end
        rd = 1'($urandom_range(0, 1));
        wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
        lr = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
        lw = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
        do_txn(a, dl, rd, wr, $urandom, lr, lw);
        idle($urandom_range(0, 2));
    endtask

    initial begin
        reset = 1'b1;
        bus.core_addr = 32'h0; bus.core_wdata = 32'h0; bus.core_dlen = 3'd4;
        bus.core_rd = 1'b0; bus.core_wr = 1'b0;
        bus.mem_rdata = 32'h0; bus.mem_response = 1'b0;
        clear_mon();
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_addr = 1'b1; exp_addr = 32'h0;
        chk_wdata = 1'b1; exp_wdata = 32'h0;
        chk_rdata = 1'b1; exp_rdata = 32'h0;
        exp_valid = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        idle(2);

        // Word load with a 3-cycle memory response.
        mem_model[32'h100] = 32'h12345678;
        clear_mon();
        do_txn(32'h100, 3'd4, 1'b1, 1'b0, 32'h0, 3, 0);
        check("t1_rdata", bus.core_rdata, 32'h12345678);
        check("t1_hlt_cycles", 32'(mon_hlt), 32'd4);
        check("t1_read_cycles", 32'(mon_rd), 32'd3);
        idle(1);

        // Byte store into the top lane: read-modify-write.
        mem_model[32'h200] = 32'h11223344;
        clear_mon();
        do_txn(32'h203, 3'd1, 1'b0, 1'b1, 32'hAB00_0000, 2, 2);
        check("t2_word", mem_model[32'h200], 32'hAB223344);
        check("t2_read_cycles", 32'(mon_rd), 32'd2);
        check("t2_write_cycles", 32'(mon_wr), 32'd2);
        idle(1);

        // Misaligned half store is dropped.
        clear_mon();
        do_txn(32'h201, 3'd2, 1'b0, 1'b1, 32'h0000_5500, 1, 1);
        check("t3_hlt_cycles", 32'(mon_hlt), 32'd1);
        check("t3_mem_activity", 32'(mon_rd + mon_wr), 32'd0);
        idle(1);

        // Load that never gets a response.
        clear_mon();
        do_txn(32'h180, 3'd4, 1'b1, 1'b0, 32'h0, 0, 0);
        check("t4_rdata", bus.core_rdata, 32'hDEADBEEF);
        check("t4_read_cycles", 32'(mon_rd), 32'd8);
        idle(1);

        // rd and wr together: a word write, no read.
        clear_mon();
        do_txn(32'h240, 3'd4, 1'b1, 1'b1, 32'hCAFE_F00D, 1, 2);
        check("t5_word", mem_model[32'h240], 32'hCAFE_F00D);
        check("t5_read_cycles", 32'(mon_rd), 32'd0);
        idle(1);

        // Response arriving on the last allowed cycle beats the timeout.
        do_txn(32'h184, 3'd4, 1'b1, 1'b0, 32'h0, TMO, 0);
        do_txn(32'h1A0, 3'd4, 1'b0, 1'b1, 32'h0BAD_CAFE, 0, TMO);
        // Sub-word store that stalls in its write half.
        do_txn(32'h2C2, 3'd2, 1'b0, 1'b1, 32'h7788_0000, 3, 0);
        idle(1);

        // Reset in the middle of a word write.
        bus.core_addr = 32'h300; bus.core_dlen = 3'd4; bus.core_wdata = 32'h5555_AAAA;
        bus.core_wr = 1'b1; bus.core_rd = 1'b0; bus.mem_response = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 2; i++) begin
            set_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc();
        end
        reset = 1'b1;
        bus.core_wr = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        reset = 1'b0;
        idle(1);
        mem_model[32'h304] = 32'h0F0F_0F0F;
        do_txn(32'h304, 3'd4, 1'b1, 1'b0, 32'h0, 2, 0);
        check("t6_rdata", bus.core_rdata, 32'h0F0F_0F0F);

        for (int t = 0; t < 120; t++) random_txn();

        exp_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
